// File: rtl/plic_int_kid_grp.sv
// Multi-source PLIC gateway: per-source edge/level capture, pending/active tracking,
// priority storage and a saturating edge-coalescing counter for edge-mode sources.
module plic_int_kid_grp #(
    parameter int NUM_INT  = 8,
    parameter int ID_W     = 3,
    parameter int PRIO_BIT = 5,
    parameter int CNT_W    = 2
) (
    input  logic                         kid_clk,
    input  logic                         plicrst_b,
    input  logic [NUM_INT-1:0]           int_vld_aft_sync,
    input  logic [NUM_INT-1:0]           pad_plic_int_cfg,
    input  logic                         busif_we_prio,
    input  logic [ID_W-1:0]              busif_prio_id,
    input  logic [PRIO_BIT-1:0]          busif_prio_data,
    input  logic                         busif_set_ip,
    input  logic                         busif_clr_ip,
    input  logic [ID_W-1:0]              busif_ip_id,
    input  logic                         hreg_claim_vld,
    input  logic [ID_W-1:0]              hreg_claim_id,
    input  logic                         hreg_complete_vld,
    input  logic [ID_W-1:0]              hreg_complete_id,
    output logic [NUM_INT-1:0]           kid_arb_int_req,
    output logic [NUM_INT*PRIO_BIT-1:0]  kid_arb_int_prio,
    output logic [NUM_INT-1:0]           kid_busif_pending,
    output logic [NUM_INT-1:0]           kid_int_active,
    output logic [NUM_INT-1:0]           kid_edge_ovf,
    output logic                         kid_sample_en
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // All bus/hart strobes are single-cycle qualifiers: an operation happens on the
    // clock edge where the strobe is high; there is no backpressure (always accepted).
    logic [NUM_INT-1:0] r_vld_ff;

    always_ff @(posedge kid_clk or negedge plicrst_b) begin
        if (!plicrst_b) begin
            r_vld_ff <= '0;
        end else begin
            r_vld_ff <= int_vld_aft_sync;
        end
    end

    assign kid_sample_en = |(int_vld_aft_sync ^ r_vld_ff);

    genvar i;
    generate
        for (i = 0; i < NUM_INT; i++) begin : g_src
            logic                w_clm;
            logic                w_cmp;
            logic                w_set;
            logic                w_clr;
            logic                w_we;
            logic                w_pulse;
            logic                w_busy;
            logic                w_edge;
            logic                w_cnt_nz;
            logic                w_pend_nxt;
            logic                r_pend;
            logic                r_act;
            logic                r_ovf;
            logic [CNT_W-1:0]    r_cnt;
            logic [PRIO_BIT-1:0] r_prio;

            // Index match against i also rejects any id >= NUM_INT.
            assign w_clm    = hreg_claim_vld & (hreg_claim_id == ID_W'(i));
            assign w_cmp    = hreg_complete_vld & (hreg_complete_id == ID_W'(i)) & r_act;
            assign w_set    = busif_set_ip & (busif_ip_id == ID_W'(i));
            assign w_clr    = busif_clr_ip & (busif_ip_id == ID_W'(i));
            assign w_we     = busif_we_prio & (busif_prio_id == ID_W'(i));
            assign w_pulse  = int_vld_aft_sync[i] & ~r_vld_ff[i];
            assign w_busy   = (r_pend | r_act) & ~w_cmp;
            assign w_edge   = pad_plic_int_cfg[i];
            assign w_cnt_nz = (r_cnt != '0);

            always_comb begin
                w_pend_nxt = r_pend;
                if (w_clr || w_clm) begin
                    w_pend_nxt = 1'b0;
                end else if (w_set) begin
                    w_pend_nxt = 1'b1;
                end else if (w_edge) begin
                    // A complete with stored edges replays one of them as a new pending.
                    if ((!w_busy && w_pulse) || (w_cmp && w_cnt_nz)) begin
                        w_pend_nxt = 1'b1;
                    end
                end else begin
                    if (((!r_act || w_cmp) && w_pulse) || (w_cmp && int_vld_aft_sync[i])) begin
                        w_pend_nxt = 1'b1;
                    end
                end
            end

            always_ff @(posedge kid_clk or negedge plicrst_b) begin
                if (!plicrst_b) begin
                    r_pend <= 1'b0;
                    r_act  <= 1'b0;
                    r_ovf  <= 1'b0;
                    r_cnt  <= '0;
                    r_prio <= '0;
                end else begin
                    r_pend <= w_pend_nxt;

                    if (w_clm) begin
                        r_act <= 1'b1;
                    end else if (w_cmp) begin
                        r_act <= 1'b0;
                    end

                    if (w_we) begin
                        r_prio <= busif_prio_data;
                    end

                    // Counter only lives in edge mode; a level source keeps it cleared.
                    if (w_clr || !w_edge) begin
                        r_cnt <= '0;
                    end else if (w_pulse && w_busy) begin
                        if (r_cnt != CNT_MAX) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (w_cmp && w_cnt_nz && !w_pulse) begin
                        r_cnt <= r_cnt - 1'b1;
                    end

                    if (w_clr) begin
                        r_ovf <= 1'b0;
                    end else if (w_edge && w_pulse && w_busy && (r_cnt == CNT_MAX)) begin
                        r_ovf <= 1'b1;
                    end
                end
            end

            assign kid_busif_pending[i] = r_pend;
            assign kid_int_active[i]    = r_act;
            assign kid_edge_ovf[i]      = r_ovf;
            assign kid_arb_int_req[i]   = r_pend & ~r_act & (|r_prio);
            assign kid_arb_int_prio[i*PRIO_BIT +: PRIO_BIT] = r_prio;
        end
    endgenerate

endmodule

// File: tb/tb_plic_int_kid_grp.sv
// Directed bench for plic_int_kid_grp: edge/level capture, coalescing counter,
// priority gating, strobe collisions, out-of-range ids and asynchronous reset.
module tb_plic_int_kid_grp;

    localparam int NUM_INT  = 8;
    localparam int ID_W     = 4;
    localparam int PRIO_BIT = 5;
    localparam int CNT_W    = 2;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_INT-1:0]          vld;
    logic [NUM_INT-1:0]          cfg;
    logic                        we_prio;
    logic [ID_W-1:0]             prio_id;
    logic [PRIO_BIT-1:0]         prio_data;
    logic                        set_ip;
    logic                        clr_ip;
    logic [ID_W-1:0]             ip_id;
    logic                        claim_vld;
    logic [ID_W-1:0]             claim_id;
    logic                        cmp_vld;
    logic [ID_W-1:0]             cmp_id;
    logic [NUM_INT-1:0]          req;
    logic [NUM_INT*PRIO_BIT-1:0] prio;
    logic [NUM_INT-1:0]          pending;
    logic [NUM_INT-1:0]          active;
    logic [NUM_INT-1:0]          ovf;
    logic                        sample_en;

    int n_checks;
    int n_fail;
    logic [NUM_INT*PRIO_BIT-1:0] exp_prio;

    plic_int_kid_grp #(
        .NUM_INT (NUM_INT),
        .ID_W    (ID_W),
        .PRIO_BIT(PRIO_BIT),
        .CNT_W   (CNT_W)
    ) dut (
        .kid_clk          (clk),
        .plicrst_b        (rst_n),
        .int_vld_aft_sync (vld),
        .pad_plic_int_cfg (cfg),
        .busif_we_prio    (we_prio),
        .busif_prio_id    (prio_id),
        .busif_prio_data  (prio_data),
        .busif_set_ip     (set_ip),
        .busif_clr_ip     (clr_ip),
        .busif_ip_id      (ip_id),
        .hreg_claim_vld   (claim_vld),
        .hreg_claim_id    (claim_id),
        .hreg_complete_vld(cmp_vld),
        .hreg_complete_id (cmp_id),
        .kid_arb_int_req  (req),
        .kid_arb_int_prio (prio),
        .kid_busif_pending(pending),
        .kid_int_active   (active),
        .kid_edge_ovf     (ovf),
        .kid_sample_en    (sample_en)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drivers: inputs change 1ns after the rising edge, outputs are checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_prio(input int id, input int data);
        we_prio = 1'b1; prio_id = ID_W'(id); prio_data = PRIO_BIT'(data);
        tick();
        we_prio = 1'b0;
    endtask

    task automatic do_set(input int id);
        set_ip = 1'b1; ip_id = ID_W'(id);
        tick();
        set_ip = 1'b0;
    endtask

    task automatic do_clr(input int id);
        clr_ip = 1'b1; ip_id = ID_W'(id);
        tick();
        clr_ip = 1'b0;
    endtask

    task automatic do_claim(input int id);
        claim_vld = 1'b1; claim_id = ID_W'(id);
        tick();
        claim_vld = 1'b0;
    endtask

    task automatic do_complete(input int id);
        cmp_vld = 1'b1; cmp_id = ID_W'(id);
        tick();
        cmp_vld = 1'b0;
    endtask

    task automatic pulse_src(input int id);
        vld[id] = 1'b1;
        tick();
        vld[id] = 1'b0;
        tick();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        rst_n = 1'b0; vld = '0; cfg = 8'b0000_1001;
        we_prio = 1'b0; prio_id = '0; prio_data = '0;
        set_ip = 1'b0; clr_ip = 1'b0; ip_id = '0;
        claim_vld = 1'b0; claim_id = '0; cmp_vld = 1'b0; cmp_id = '0;
        exp_prio = '0;

        tick(); tick();
        check_val("rst_pending", 64'(pending), 64'h0);
        check_val("rst_active", 64'(active), 64'h0);
        check_val("rst_req", 64'(req), 64'h0);
        check_val("rst_prio", 64'(prio), 64'h0);
        check_val("rst_ovf", 64'(ovf), 64'h0);
        check_val("rst_sample_en", 64'(sample_en), 64'h0);
        rst_n = 1'b1;
        tick();

        // Edge source 3, prio 4: one-cycle latency, claim, complete without re-pend
        write_prio(3, 4);
        exp_prio[3*PRIO_BIT +: PRIO_BIT] = 5'd4;
        check_val("prio3", 64'(prio), 64'(exp_prio));
        vld[3] = 1'b1;
        #1;
        check_val("sample_en_hi", 64'(sample_en), 64'h1);
        tick();
        check_val("e3_pending", 64'(pending), 64'h08);
        check_val("e3_req", 64'(req), 64'h08);
        check_val("sample_en_lo", 64'(sample_en), 64'h0);
        do_claim(3);
        check_val("e3_clm_pending", 64'(pending), 64'h00);
        check_val("e3_clm_active", 64'(active), 64'h08);
        check_val("e3_clm_req", 64'(req), 64'h00);
        do_complete(3);
        check_val("e3_cmp_active", 64'(active), 64'h00);
        check_val("e3_cmp_pending", 64'(pending), 64'h00);
        vld[3] = 1'b0;
        tick();

        // Edge source 0: coalesce 5 edges while active, saturate and overflow
        write_prio(0, 7);
        exp_prio[0 +: PRIO_BIT] = 5'd7;
        pulse_src(0);
        check_val("e0_pending", 64'(pending), 64'h01);
        do_claim(0);
        for (int e = 0; e < 5; e++) begin
            pulse_src(0);
            if (e == 2) check_val("e0_ovf_before_sat", 64'(ovf), 64'h0);
        end
        check_val("e0_ovf_set", 64'(ovf), 64'h01);
        check_val("e0_busy_pending", 64'(pending), 64'h00);
        for (int k = 0; k < 3; k++) begin
            do_complete(0);
            check_val($sformatf("e0_replay%0d_pending", k), 64'(pending), 64'h01);
            check_val($sformatf("e0_replay%0d_active", k), 64'(active), 64'h00);
            do_claim(0);
        end
        do_complete(0);
        check_val("e0_drained_pending", 64'(pending), 64'h00);
        check_val("e0_drained_active", 64'(active), 64'h00);
        check_val("e0_ovf_sticky", 64'(ovf), 64'h01);
        do_clr(0);
        check_val("e0_ovf_clr", 64'(ovf), 64'h00);

        // Level source 5: line held through complete re-pends; dropped line does not
        write_prio(5, 2);
        exp_prio[5*PRIO_BIT +: PRIO_BIT] = 5'd2;
        vld[5] = 1'b1;
        tick();
        check_val("l5_pending", 64'(pending), 64'h20);
        check_val("l5_req", 64'(req), 64'h20);
        do_claim(5);
        check_val("l5_active", 64'(active), 64'h20);
        do_complete(5);
        check_val("l5_repend", 64'(pending), 64'h20);
        check_val("l5_repend_active", 64'(active), 64'h00);
        do_claim(5);
        vld[5] = 1'b0;
        tick();
        do_complete(5);
        check_val("l5_no_repend", 64'(pending), 64'h00);
        check_val("l5_done_active", 64'(active), 64'h00);

        // Source 2: zero priority masks the request; set+clr together clears
        do_set(2);
        check_val("p2_pending", 64'(pending), 64'h04);
        check_val("p2_req_masked", 64'(req), 64'h00);
        write_prio(2, 1);
        exp_prio[2*PRIO_BIT +: PRIO_BIT] = 5'd1;
        check_val("p2_req", 64'(req), 64'h04);
        set_ip = 1'b1; clr_ip = 1'b1; ip_id = 4'd2;
        tick();
        set_ip = 1'b0; clr_ip = 1'b0;
        check_val("p2_setclr", 64'(pending), 64'h00);

        // Collisions: complete on non-active, claim+complete same id
        do_set(4);
        do_complete(4);
        check_val("c4_cmp_ignored_pend", 64'(pending), 64'h10);
        check_val("c4_cmp_ignored_act", 64'(active), 64'h00);
        do_claim(4);
        claim_vld = 1'b1; claim_id = 4'd4; cmp_vld = 1'b1; cmp_id = 4'd4;
        tick();
        claim_vld = 1'b0; cmp_vld = 1'b0;
        check_val("c4_claim_wins", 64'(active), 64'h10);
        do_complete(4);
        check_val("c4_released", 64'(active), 64'h00);

        // Out-of-range id 9 on every strobe: no state change
        set_ip = 1'b1; ip_id = 4'd9;
        we_prio = 1'b1; prio_id = 4'd9; prio_data = 5'd31;
        claim_vld = 1'b1; claim_id = 4'd9;
        tick();
        set_ip = 1'b0; we_prio = 1'b0; claim_vld = 1'b0;
        clr_ip = 1'b1; ip_id = 4'd9;
        tick();
        clr_ip = 1'b0;
        check_val("id9_pending", 64'(pending), 64'h00);
        check_val("id9_active", 64'(active), 64'h00);
        check_val("id9_prio", 64'(prio), 64'(exp_prio));

        // Asynchronous reset in the middle of activity
        do_set(6);
        pulse_src(0);
        do_claim(0);
        pulse_src(0);
        do_set(3);
        check_val("pre_rst_pending", 64'(pending), 64'h48);
        check_val("pre_rst_active", 64'(active), 64'h01);
        check_val("pre_rst_req", 64'(req), 64'h08);
        rst_n = 1'b0; vld = '0;
        #1;
        check_val("arst_pending", 64'(pending), 64'h00);
        check_val("arst_active", 64'(active), 64'h00);
        check_val("arst_req", 64'(req), 64'h00);
        check_val("arst_prio", 64'(prio), 64'h0);
        check_val("arst_ovf", 64'(ovf), 64'h00);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();
        check_val("post_rst_pending", 64'(pending), 64'h00);
        check_val("post_rst_active", 64'(active), 64'h00);
        check_val("post_rst_req", 64'(req), 64'h00);
        check_val("post_rst_sample_en", 64'(sample_en), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/plic_int_kid_grp.md
Name: plic_int_kid_grp

Overview:
- Parametrised successor of the single-source PLIC gateway: one instance serves NUM_INT interrupt sources.
- Each source has a per-source edge/level mode, priority, pending and active state.
- Each edge-mode source also has a saturating edge-coalescing counter, so edges that arrive while the source is busy are not lost.
- Sits between the synchronised interrupt inputs and the PLIC arbiter / bus interface / hart-register (claim/complete) logic.

Parameters:
- NUM_INT, 8: number of sources handled by the instance.
- ID_W, 3: source-index width; must satisfy 2^ID_W >= NUM_INT.
- PRIO_BIT, 5: priority width.
- CNT_W, 2: edge-counter width; the counter saturates at 2^CNT_W-1.

Ports:
- kid_clk  in  1  block clock
- plicrst_b  in  1  asynchronous active-low reset
- int_vld_aft_sync  in  NUM_INT  synchronised interrupt lines; bit i = source i
- pad_plic_int_cfg  in  NUM_INT  per-source mode; 1 = edge, 0 = level
- busif_we_prio  in  1  priority write strobe
- busif_prio_id  in  ID_W  source index for the priority write
- busif_prio_data  in  PRIO_BIT  priority write data
- busif_set_ip  in  1  set-pending strobe
- busif_clr_ip  in  1  clear-pending strobe
- busif_ip_id  in  ID_W  source index for set/clr
- hreg_claim_vld  in  1  claim strobe
- hreg_claim_id  in  ID_W  claimed source index
- hreg_complete_vld  in  1  complete strobe
- hreg_complete_id  in  ID_W  completed source index
- kid_arb_int_req  out  NUM_INT  per-source request to the arbiter
- kid_arb_int_prio  out  NUM_INT*PRIO_BIT  flattened priorities; source i occupies bits [i*PRIO_BIT +: PRIO_BIT]
- kid_busif_pending  out  NUM_INT  pending bits
- kid_int_active  out  NUM_INT  active (claimed, not yet completed) bits
- kid_edge_ovf  out  NUM_INT  sticky edge-counter overflow flags
- kid_sample_en  out  1  high when any input differs from its sampled value (clock-gate enable)

Behaviour:
- Reset: all registers clear. Every output resets to 0: req, prio, pending, active, ovf, sample_en (int_vld_ff = 0, so sample_en follows the inputs combinationally once reset releases).
- Any strobe whose index is >= NUM_INT is ignored.
- Per-source decodes: clm_i = hreg_claim_vld & id==i; cmp_i = hreg_complete_vld & id==i & active_i; set_i and clr_i decode the same way from busif_ip_id.
- A complete on a non-active source is ignored.
- Edge detect: vld_ff_i <= int_vld_i every cycle; pulse_i = int_vld_i & !vld_ff_i.
- kid_sample_en = OR over i of (int_vld_i ^ vld_ff_i).
- busy_i = (pending_i | active_i) & !cmp_i.
- Pending next-state, in priority order:
  1. clr_i or clm_i -> 0.
  2. set_i -> 1.
  3. Edge mode, !busy_i and pulse_i -> 1.
  4. Edge mode, cmp_i and cnt_i != 0 -> 1 (counted edge replayed).
  5. Level mode, (!active_i or cmp_i) and pulse_i -> 1.
  6. Level mode, cmp_i and int_vld_i high -> 1.
  7. Otherwise hold.
- Edge counter cnt_i, CNT_W bits:
  - Clears on clr_i, or whenever the source is in level mode.
  - Edge mode, pulse_i while busy_i: increment, saturating at max.
  - A pulse while cnt_i == max sets ovf_i instead.
  - Edge mode, cmp_i with cnt_i != 0 and no pulse: decrement.
  - Edge mode, cmp_i with a simultaneous pulse: hold (one consumed, one added).
- kid_edge_ovf bit i is sticky; it is cleared only by clr_i or reset.
- Active: clm_i -> 1; else cmp_i -> 0. Claim and complete to the same source in one cycle: claim wins, active stays 1.
- Priority: busif_we_prio with a valid id loads busif_prio_data on the next edge; no read-modify-write.
- kid_arb_int_req_i = pending_i & !active_i & (prio_i != 0). Combinational from registers, no added latency.
- Latency: an input edge at cycle N gives pending and req visible at N+1.
- Mode change: cfg changes take effect in the same cycle. A switch to level discards the counter; pending and active are unaffected.

Test Plan:
- Edge mode, src 3, prio 4: raise int at cycle 10 -> pending[3]=1 and req[3]=1 at 11. Claim id 3 -> pending 0, active 1, req 0. Complete -> active 0, no re-pend.
- Edge mode, src 0 claimed: 5 edges while active with CNT_W=2 -> cnt saturates at 3, ovf[0]=1. Each of the following 3 completes re-pends src 0; after the 4th complete, pending stays 0. ovf[0] stays 1 until busif_clr_ip id 0.
- Level mode, src 5: hold line high through claim/complete -> re-pends the cycle after complete. Drop the line before complete -> no re-pend.
- Priority 0 on src 2 with pending=1 -> req[2]=0. Write prio 1 -> req[2]=1 next cycle. busif_clr_ip together with busif_set_ip on id 2 -> pending 0.
- Collisions: complete on a non-active src is ignored. Claim and complete same cycle, same id -> active stays 1. Strobe with id 9 (NUM_INT=8) -> no state change.
- Assert plicrst_b low mid-operation with several sources pending, active and counting -> all outputs 0 immediately, no re-pend after release.
